// File: rtl/seq_div.sv
// Sequential restoring divider: one quotient bit per clock, registered
// quotient/remainder with a one-cycle done pulse and a divide-by-zero flag.
module seq_div #(
   parameter int DW = 8,
   parameter int VW = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   input  logic [DW-1:0] dividend,
   input  logic [VW-1:0] divisor,
   output logic [DW-1:0] quotient,
   output logic [VW-1:0] remainder,
   output logic          busy,
   output logic          done,
   output logic          div_by_zero
);

   localparam int CW = $clog2(DW + 1);

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      CALC = 1'b1
   } state_t;

   state_t        state_r;
   logic [DW-1:0] q_r;
   logic [VW-1:0] d_r;
   // After every restoring step R < D, so the MSB of the (VW+1)-bit
   // partial remainder is always zero and is not stored.
   logic [VW-1:0] r_r;
   logic [CW-1:0] cnt_r;
   logic          dz_pend_r;

   logic [VW:0]   t_s;
   logic [VW:0]   diff_s;
   logic          ge_s;
   logic [DW-1:0] q_nxt_s;
   logic [VW-1:0] r_nxt_s;

   // One restoring step: trial subtract of the divisor from the shifted remainder.
   always_comb begin
      t_s     = {r_r, q_r[DW-1]};
      diff_s  = t_s - {1'b0, d_r};
      ge_s    = (t_s >= {1'b0, d_r});
      q_nxt_s = {q_r[DW-2:0], ge_s};
      if (ge_s) begin
         r_nxt_s = diff_s[VW-1:0];
      end else begin
         r_nxt_s = t_s[VW-1:0];
      end
   end

   // Control FSM, datapath registers and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= IDLE;
         q_r         <= '0;
         d_r         <= '0;
         r_r         <= '0;
         cnt_r       <= '0;
         dz_pend_r   <= 1'b0;
         quotient    <= '0;
         remainder   <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         div_by_zero <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state_r)
            IDLE: begin
               if (dz_pend_r) begin
                  // Divide-by-zero result is reported one edge after the start.
                  dz_pend_r   <= 1'b0;
                  done        <= 1'b1;
                  div_by_zero <= 1'b1;
                  quotient    <= '1;
                  remainder   <= '0;
               end else if (start) begin
                  if (divisor != '0) begin
                     q_r     <= dividend;
                     d_r     <= divisor;
                     r_r     <= '0;
                     cnt_r   <= CW'(DW);
                     busy    <= 1'b1;
                     state_r <= CALC;
                  end else begin
                     dz_pend_r <= 1'b1;
                  end
               end else begin
                  state_r <= IDLE;
               end
            end
            CALC: begin
               q_r   <= q_nxt_s;
               r_r   <= r_nxt_s;
               cnt_r <= cnt_r - CW'(1);
               if (cnt_r == CW'(1)) begin
                  quotient    <= q_nxt_s;
                  remainder   <= r_nxt_s;
                  done        <= 1'b1;
                  div_by_zero <= 1'b0;
                  busy        <= 1'b0;
                  state_r     <= IDLE;
               end else begin
                  state_r <= CALC;
               end
            end
            default: begin
               state_r <= IDLE;
               busy    <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: doc/seq_div.md
# seq_div

Sequential restoring divider, the inverse companion to the team's `seq_mul` shift-add multiplier. It accepts an unsigned DW-bit dividend and a VW-bit divisor on a `start` pulse. It produces one quotient bit per clock and returns the quotient and remainder with a one-cycle `done` pulse. It sits next to `seq_mul` in the arithmetic datapath, so a product from `seq_mul` can be divided back by either original operand.

## Interface
- `DW`, 8, dividend/quotient width; must satisfy DW >= VW
- `VW`, 4, divisor/remainder width
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous active-low reset
- `start`  in  1  sampled each rising edge; begins a division when sampled high in IDLE
- `dividend`  in  DW  unsigned dividend, captured on the start edge
- `divisor`  in  VW  unsigned divisor, captured on the start edge
- `quotient`  out  DW  unsigned quotient, registered
- `remainder`  out  VW  unsigned remainder, registered
- `busy`  out  1  high while a division is in progress
- `done`  out  1  one-cycle pulse: result valid
- `div_by_zero`  out  1  flag qualified by `done`; high when divisor was 0

## Operation
- States: IDLE, CALC.
- Reset (rst_n low, asynchronous):
  - state = IDLE
  - quotient = 0, remainder = 0
  - busy = 0, done = 0, div_by_zero = 0
  - internal registers cleared
- IDLE with start = 1 and divisor != 0:
  - capture dividend into shift register Q and divisor into D
  - clear partial remainder R (VW+1 bits)
  - iteration counter = DW
  - busy = 1; go to CALC
- IDLE with start = 1 and divisor == 0:
  - stay in IDLE
  - next edge drives done = 1, div_by_zero = 1, quotient = all ones, remainder = 0
- CALC, each edge runs one restoring step:
  - T = {R[VW-1:0], Q[DW-1]}
  - shift Q left
  - if T >= {1'b0, D}: R = T − D and Q[0] = 1
  - else: R = T and Q[0] = 0
  - decrement counter
- CALC step with counter reaching 0 (last step):
  - load quotient and remainder from the final Q and R[VW-1:0]
  - done = 1, div_by_zero = 0, busy = 0; go to IDLE
- Arithmetic:
  - all unsigned
  - remainder < divisor always holds
  - quotient × divisor + remainder == dividend
- `start` while busy is ignored: no restart and no operand recapture.
- `done` is high for exactly one cycle per accepted start. `quotient`, `remainder` and `div_by_zero` hold until the next result.
- Reset mid-CALC aborts the operation immediately. No `done` is produced.

## Timing
- Let start be sampled high in IDLE at edge N, with a nonzero divisor.
  - busy is high after edge N through edge N+DW.
  - done is high for the cycle after edge N+DW.
  - Latency is DW cycles (8 at default).
- Divide by zero: start at edge N gives done and div_by_zero high after edge N+1, with busy never asserted.
- Back-to-back: start may be high in the same cycle that done is high. It is accepted at that edge, because the state is already IDLE.
- Operands need to be valid only on the start edge. They may change freely afterwards.
- Outputs are registered, with no combinational path from the inputs.

## Test plan
- Reset: hold rst_n low across several edges with start toggling -> all outputs 0. Release, then dividend=117, divisor=13, start pulsed -> done after 8 cycles, quotient=9, remainder=0.
- Sweep:
  - 200/7 -> quotient 28, remainder 4
  - 255/1 -> 255, 0
  - 5/9 -> 0, 5
  - 255/15 -> 17, 0
  - each with done exactly 8 cycles after start and one cycle wide.
- Divide by zero: dividend=42, divisor=0 -> done and div_by_zero 1 cycle later, quotient=8'hFF, remainder=0, busy stays 0. A following 42/6 -> quotient 7, remainder 0, div_by_zero=0.
- Start while busy: launch 100/3, re-pulse start with 50/5 at cycle 3 -> only one done, quotient=33, remainder=1.
- Back-to-back: assert start with 99/10 in the cycle done of 117/13 is high -> second done 8 cycles later, quotient=9, remainder=9.
- Reset mid-operation: launch 200/7, drop rst_n at cycle 4 -> outputs 0 at once, no done. After release, 60/4 -> quotient 15, remainder 0.
